car_light_seq: RTL and testbench

Parametrised sequential turn-signal controller for the car-light board, the next generation of the two-signal flowing-LED car light. It decodes the 4-bit `car_status` switch input into a registered mode (idle, left, right, hazard) plus a brake overlay. It drives an N-LED active-low status bar with a sequential "sweep" pattern per side, and drives two active-low RGB indicator LEDs. It sits directly under the board top level, fed by raw switches, and owns all timing internally.

---
 rtl/car_light_pkg.sv | 28 ++
 rtl/car_light_tick.sv | 28 ++
 rtl/car_light_seq.sv | 119 +++++++++++
 tb/tb_car_light_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/car_light_pkg.sv
// Shared types and constants for the car-light turn-signal sequencer.
package car_light_pkg;

  typedef enum logic [1:0] {
    ModeIdle   = 2'd0,
    ModeLeft   = 2'd1,
    ModeRight  = 2'd2,
    ModeHazard = 2'd3
  } car_mode_t;

  localparam int unsigned CS_LEFT   = 0;
  localparam int unsigned CS_RIGHT  = 1;
  localparam int unsigned CS_BRAKE  = 2;
  localparam int unsigned CS_HAZARD = 3;

  localparam logic [2:0] RGB_OFF    = 3'b111;
  localparam logic [2:0] RGB_RED    = 3'b011;
  localparam logic [2:0] RGB_YELLOW = 3'b001;

  // Both turn switches together are treated as a hazard request.
  function automatic car_mode_t decode_mode(input logic [3:0] cs);
    if (cs[CS_HAZARD] || (cs[CS_LEFT] && cs[CS_RIGHT])) return ModeHazard;
    if (cs[CS_LEFT])  return ModeLeft;
    if (cs[CS_RIGHT]) return ModeRight;
    return ModeIdle;
  endfunction

endpackage

// File: rtl/car_light_tick.sv
// Free-running prescaler: one-cycle tick every DIV cycles, restartable via clr.
module car_light_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr || tick) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/car_light_seq.sv
// Turn-signal sequencer: synchronises switches, decodes mode, sweeps the LED bar
// and drives the RGB indicators. All outputs are registered.
module car_light_seq
  import car_light_pkg::*;
#(
  parameter int unsigned N_LED   = 8,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned STEP_HZ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       car_status,
  output logic [N_LED-1:0] status_led_n,
  output logic [2:0]       rgb_led_1_n,
  output logic [2:0]       rgb_led_2_n,
  output logic [1:0]       mode
);

  localparam int unsigned H   = N_LED / 2;
  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned KW  = $clog2(H + 1);
  localparam logic [KW-1:0] KMAX = KW'(H);

  logic [3:0]       cs_meta_q, cs_q;
  car_mode_t        state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             phase_q, phase_d;
  logic             changed, tick;
  logic [N_LED-1:0] led_n_q, led_n_d;
  logic [N_LED-1:0] ones_k;
  logic [2:0]       rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic             left_on, right_on;

  car_light_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (changed),
    .tick (tick)
  );

  // A mode change wins over a coincident tick.
  always_comb begin
    state_d = decode_mode(cs_q);
    changed = (state_d != state_q);
    k_d     = k_q;
    phase_d = phase_q;
    if (changed) begin
      k_d     = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        ModeLeft, ModeRight: k_d = (k_q == KMAX) ? '0 : k_q + 1'b1;
        ModeHazard:          phase_d = ~phase_q;
        default: ;
      endcase
    end
  end

  // Outputs are derived from next-state so they land with the mode register.
  always_comb begin
    led_n_d  = '1;
    left_on  = 1'b0;
    right_on = 1'b0;
    ones_k   = ~({N_LED{1'b1}} << k_d);
    case (state_d)
      ModeLeft: begin
        led_n_d = ~(ones_k << H);
        left_on = (k_d != '0);
      end
      ModeRight: begin
        led_n_d  = ~(ones_k << (H - 32'(k_d)));
        right_on = (k_d != '0);
      end
      ModeHazard: begin
        led_n_d  = phase_d ? '0 : '1;
        left_on  = phase_d;
        right_on = phase_d;
      end
      default: ;
    endcase
    if (cs_q[CS_BRAKE]) begin
      rgb1_d = RGB_RED;
      rgb2_d = RGB_RED;
    end else begin
      rgb1_d = left_on  ? RGB_YELLOW : RGB_OFF;
      rgb2_d = right_on ? RGB_YELLOW : RGB_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q <= '0;
      cs_q      <= '0;
      state_q   <= ModeIdle;
      k_q       <= '0;
      phase_q   <= 1'b0;
      led_n_q   <= '1;
      rgb1_q    <= RGB_OFF;
      rgb2_q    <= RGB_OFF;
    end else begin
      cs_meta_q <= car_status;
      cs_q      <= cs_meta_q;
      state_q   <= state_d;
      k_q       <= k_d;
      phase_q   <= phase_d;
      led_n_q   <= led_n_d;
      rgb1_q    <= rgb1_d;
      rgb2_q    <= rgb2_d;
    end
  end

  assign status_led_n = led_n_q;
  assign rgb_led_1_n  = rgb1_q;
  assign rgb_led_2_n  = rgb2_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_car_light_seq.sv
// Bench for car_light_seq: elapsed-time reference model compared every cycle,
// plus directed literal checks and a randomized switch-toggling phase.
module tb_car_light_seq;

  localparam int N_LED = 8;
  localparam int H     = 4;
  localparam int DIV   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] car_status = 4'b0;
  logic [7:0] status_led_n;
  logic [2:0] rgb_led_1_n, rgb_led_2_n;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  car_light_seq #(
    .N_LED   (N_LED),
    .CLK_HZ  (40),
    .STEP_HZ (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .car_status   (car_status),
    .status_led_n (status_led_n),
    .rgb_led_1_n  (rgb_led_1_n),
    .rgb_led_2_n  (rgb_led_2_n),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  // Reference model: mode from switches seen two edges ago, pattern from time in mode.
  logic [3:0] h1 = 4'b0, h2 = 4'b0;
  int         m_mode = 0, m_time = 0, nm;
  bit         m_brake = 1'b0;
  logic [7:0] exp_bar = 8'hFF;
  logic [2:0] exp_rgb1 = 3'b111, exp_rgb2 = 3'b111;

  function automatic int ref_decode(input logic [3:0] s);
    if (s[3] || (s[0] && s[1])) return 3;
    if (s[0]) return 1;
    if (s[1]) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] ref_bar(input int m, input int tt);
    int steps = tt / DIV;
    int k = steps % (H + 1);
    logic [7:0] lit = 8'h00;
    if (m == 1) for (int i = 0; i < k; i++) lit[H + i] = 1'b1;
    if (m == 2) for (int i = 0; i < k; i++) lit[H - 1 - i] = 1'b1;
    if (m == 3 && (steps % 2) == 1) lit = 8'hFF;
    return ~lit;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h1 = 4'b0; h2 = 4'b0; m_mode = 0; m_time = 0; m_brake = 1'b0;
    end else begin
      nm = ref_decode(h2);
      if (nm != m_mode) m_time = 0;
      else              m_time = m_time + 1;
      m_mode  = nm;
      m_brake = h2[2];
      h2 = h1;
      h1 = car_status;
    end
    exp_bar  = ref_bar(m_mode, m_time);
    exp_rgb1 = 3'b111;
    exp_rgb2 = 3'b111;
    if ((m_mode == 1 || m_mode == 3) && exp_bar != 8'hFF) exp_rgb1 = 3'b001;
    if ((m_mode == 2 || m_mode == 3) && exp_bar != 8'hFF) exp_rgb2 = 3'b001;
    if (m_brake) begin
      exp_rgb1 = 3'b011;
      exp_rgb2 = 3'b011;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_mode", {6'b0, mode}, 8'(m_mode));
      check("model_bar", status_led_n, exp_bar);
      check("model_rgb1", {5'b0, rgb_led_1_n}, {5'b0, exp_rgb1});
      check("model_rgb2", {5'b0, rgb_led_2_n}, {5'b0, exp_rgb2});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [1:0] m, input logic [7:0] bar,
                            input logic [2:0] r1, input logic [2:0] r2);
    check({name, "_mode"}, {6'b0, mode}, {6'b0, m});
    check({name, "_bar"}, status_led_n, bar);
    check({name, "_rgb1"}, {5'b0, rgb_led_1_n}, {5'b0, r1});
    check({name, "_rgb2"}, {5'b0, rgb_led_2_n}, {5'b0, r2});
  endtask

  initial begin
    logic [7:0] left_seq [5];
    logic [7:0] right_seq [5];
    int hold;
    left_seq  = '{8'hEF, 8'hCF, 8'h8F, 8'h0F, 8'hFF};
    right_seq = '{8'hF7, 8'hF3, 8'hF1, 8'hF0, 8'hFF};

    // Reset
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    wait_cycles(2);
    expect_out("reset", 2'd0, 8'hFF, 3'b111, 3'b111);
    rst = 1'b0;
    wait_cycles(6);
    expect_out("idle_hold", 2'd0, 8'hFF, 3'b111, 3'b111);

    // Left sweep
    car_status = 4'b0001;
    wait_cycles(3);
    expect_out("left_enter", 2'd1, 8'hFF, 3'b111, 3'b111);
    for (int i = 0; i < 5; i++) begin
      wait_cycles(DIV);
      expect_out("left_step", 2'd1, left_seq[i], (i < 4) ? 3'b001 : 3'b111, 3'b111);
    end

    // Right sweep, then switch to left at step 2
    car_status = 4'b0010;
    wait_cycles(3);
    expect_out("right_enter", 2'd2, 8'hFF, 3'b111, 3'b111);
    for (int i = 0; i < 5; i++) begin
      wait_cycles(DIV);
      expect_out("right_step", 2'd2, right_seq[i], 3'b111, (i < 4) ? 3'b001 : 3'b111);
    end
    wait_cycles(2 * DIV);
    check("right_step2", status_led_n, 8'hF3);
    car_status = 4'b0001;
    wait_cycles(3);
    expect_out("switch_left", 2'd1, 8'hFF, 3'b111, 3'b111);
    wait_cycles(DIV - 1);
    check("switch_left_early", status_led_n, 8'hFF);
    wait_cycles(1);
    expect_out("switch_left_step", 2'd1, 8'hEF, 3'b001, 3'b111);

    // Hazard via both turn bits
    car_status = 4'b0011;
    wait_cycles(3);
    expect_out("hazard_enter", 2'd3, 8'hFF, 3'b111, 3'b111);
    wait_cycles(DIV);
    expect_out("hazard_on", 2'd3, 8'h00, 3'b001, 3'b001);
    wait_cycles(DIV);
    expect_out("hazard_off", 2'd3, 8'hFF, 3'b111, 3'b111);

    // Brake overlay during left
    car_status = 4'b0001;
    wait_cycles(3 + DIV);
    check("brake_pre", status_led_n, 8'hEF);
    car_status = 4'b0101;
    wait_cycles(3);
    expect_out("brake_on", 2'd1, 8'hEF, 3'b011, 3'b011);
    wait_cycles(DIV);
    expect_out("brake_sweep", 2'd1, 8'hCF, 3'b011, 3'b011);
    car_status = 4'b0001;
    wait_cycles(3);
    expect_out("brake_off", 2'd1, 8'hCF, 3'b001, 3'b111);

    // Reset mid-hazard
    car_status = 4'b0011;
    wait_cycles(3 + DIV);
    check("hazard_pre_rst", status_led_n, 8'h00);
    rst = 1'b1;
    wait_cycles(1);
    expect_out("mid_reset", 2'd0, 8'hFF, 3'b111, 3'b111);
    rst = 1'b0;
    wait_cycles(3);
    expect_out("reacquire", 2'd3, 8'hFF, 3'b111, 3'b111);
    wait_cycles(DIV);
    expect_out("reacquire_toggle", 2'd3, 8'h00, 3'b001, 3'b001);

    // Randomized switching with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      car_status = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        wait_cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      hold = $urandom_range(1, 40);
      wait_cycles(hold);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
